// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike-train decoder blocks.
//   dec_state_t : decoder FSM states
//   isi_none()  : all-ones "no interval seen" code for a given ISI width
package snn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } dec_state_t;

   // All-ones value of width w (w <= 32), used as the "fewer than 2 spikes" marker.
   function automatic logic [31:0] isi_none(input int unsigned w);
      if (w >= 32) begin
         return '1;
      end
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/isi_tracker.sv
// Tracks inter-spike intervals within one decode window.
// Ports:
//   clk, rst    clock, async active-high reset
//   active      window cycle in progress (state COUNT with enable high)
//   win_start   current cycle is window cycle 0; prior history is ignored
//   spike_in    spike train sample
//   min_isi_c   running minimum ISI including the current cycle's spike
module isi_tracker
   import snn_pkg::*;
#(
   parameter int unsigned ISI_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active,
   input  logic             win_start,
   input  logic             spike_in,
   output logic [ISI_W-1:0] min_isi_c
);

   localparam logic [ISI_W-1:0] ISI_NONE = ISI_W'(isi_none(ISI_W));

   logic [ISI_W-1:0] isi_ctr_q;
   logic [ISI_W-1:0] min_isi_q;
   logic             seen_spike_q;

   logic [ISI_W-1:0] ctr_eff;
   logic [ISI_W-1:0] min_eff;
   logic             seen_eff;
   logic [ISI_W-1:0] gap_c;
   logic [ISI_W-1:0] isi_ctr_d;
   logic             seen_spike_d;

   // Effective history (fresh at window start), next-state and running minimum.
   always_comb begin
      ctr_eff      = win_start ? '0 : isi_ctr_q;
      min_eff      = win_start ? ISI_NONE : min_isi_q;
      seen_eff     = win_start ? 1'b0 : seen_spike_q;
      // Distance from the previous spike to this cycle, saturating.
      gap_c        = (ctr_eff == ISI_NONE) ? ISI_NONE : ctr_eff + ISI_W'(1);
      isi_ctr_d    = gap_c;
      seen_spike_d = seen_eff;
      min_isi_c    = min_eff;
      if (spike_in) begin
         isi_ctr_d    = '0;
         seen_spike_d = 1'b1;
         if (seen_eff && (gap_c < min_eff)) begin
            min_isi_c = gap_c;
         end
      end
   end

   // History registers; cleared whenever no window is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isi_ctr_q    <= '0;
         min_isi_q    <= ISI_NONE;
         seen_spike_q <= 1'b0;
      end else if (active) begin
         isi_ctr_q    <= isi_ctr_d;
         min_isi_q    <= min_isi_c;
         seen_spike_q <= seen_spike_d;
      end else begin
         isi_ctr_q    <= '0;
         min_isi_q    <= ISI_NONE;
         seen_spike_q <= 1'b0;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a 1-bit spike train per fixed-length window into spike count and
// minimum inter-spike interval, delivered through a valid/ready output register.
// Ports:
//   clk, rst      clock, async active-high reset
//   enable        1 = decode back-to-back windows, 0 = idle (partial window dropped)
//   win_len       window length in cycles, sampled at window start (0 acts as 1)
//   spike_in      spike train
//   out_valid     result pending
//   out_ready     downstream accept
//   out_count     spikes in window (saturating)
//   out_min_isi   smallest spike-to-spike distance, all-ones if < 2 spikes
//   out_overrun   at least one result was dropped before this one
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int unsigned WIN_W = 8,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned ISI_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIN_W-1:0] win_len,
   input  logic             spike_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [ISI_W-1:0] out_min_isi,
   output logic             out_overrun
);

   dec_state_t       state_q;
   dec_state_t       state_d;
   logic [WIN_W-1:0] len_q;
   logic [WIN_W-1:0] win_cnt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             overrun_q;

   logic [WIN_W-1:0] len_in_c;
   logic             counting_c;
   logic             last_c;
   logic             win_start_c;
   logic             latch_len_c;
   logic [CNT_W-1:0] cnt_sum_c;
   logic             load_c;
   logic             drop_c;
   logic             accept_c;
   logic [ISI_W-1:0] min_isi_c;

   // Window control and handshake decisions.
   always_comb begin
      len_in_c    = (win_len == '0) ? WIN_W'(1) : win_len;
      counting_c  = (state_q == COUNT) && enable;
      win_start_c = (win_cnt_q == '0);
      last_c      = counting_c && (win_cnt_q == len_q - WIN_W'(1));
      // A new window begins after entering COUNT or right after a window closes.
      latch_len_c = ((state_q == IDLE) && enable) || last_c;
      cnt_sum_c   = (spike_in && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
      accept_c    = out_valid && out_ready;
      load_c      = last_c && (!out_valid || out_ready);
      drop_c      = last_c && out_valid && !out_ready;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = COUNT;
         COUNT:   if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Window counter, spike counter and window length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         win_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         if (latch_len_c) begin
            len_q <= len_in_c;
         end
         if (counting_c && !last_c) begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            cnt_q     <= cnt_sum_c;
         end else begin
            win_cnt_q <= '0;
            cnt_q     <= '0;
         end
      end
   end

   // Output register and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_count   <= '0;
         out_min_isi <= '0;
         out_overrun <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (load_c) begin
            out_valid   <= 1'b1;
            out_count   <= cnt_sum_c;
            out_min_isi <= min_isi_c;
            out_overrun <= overrun_q;
            overrun_q   <= 1'b0;
         end else if (accept_c) begin
            out_valid <= 1'b0;
         end
         if (drop_c) begin
            overrun_q <= 1'b1;
         end
      end
   end

   isi_tracker #(
      .ISI_W(ISI_W)
   ) u_isi (
      .clk       (clk),
      .rst       (rst),
      .active    (counting_c),
      .win_start (win_start_c),
      .spike_in  (spike_in),
      .min_isi_c (min_isi_c)
   );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus randomized
// back-to-back windows compared against a per-window spike-list model.
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] win_len;
   logic       spike_in;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_count;
   logic [7:0] out_min_isi;
   logic       out_overrun;
   logic       o4_valid;
   logic [3:0] o4_count;
   logic [7:0] o4_min_isi;
   logic       o4_overrun;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   spike_rate_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .win_len     (win_len),
      .spike_in    (spike_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .out_min_isi (out_min_isi),
      .out_overrun (out_overrun)
   );

   spike_rate_decoder #(.CNT_W(4)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .win_len     (win_len),
      .spike_in    (spike_in),
      .out_valid   (o4_valid),
      .out_ready   (out_ready),
      .out_count   (o4_count),
      .out_min_isi (o4_min_isi),
      .out_overrun (o4_overrun)
   );

   // Reference model: spikes counted and distances taken directly from the pattern.
   function automatic int m_count(input logic [255:0] pat, input int len, input int maxc);
      int n = 0;
      for (int i = 0; i < len; i++) if (pat[i]) n++;
      return (n > maxc) ? maxc : n;
   endfunction

   function automatic int m_isi(input logic [255:0] pat, input int len);
      int prev = -1;
      int m = 255;
      for (int i = 0; i < len; i++) begin
         if (pat[i]) begin
            if (prev >= 0 && (i - prev) < m) m = i - prev;
            prev = i;
         end
      end
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int wl);
      win_len  = 8'(wl);
      enable   = 1'b1;
      spike_in = 1'b0;
      tick();
   endtask

   task automatic stop();
      enable   = 1'b0;
      spike_in = 1'b0;
      tick();
      tick();
   endtask

   // Drive one window; next_wl is presented on the last cycle for the following window.
   task automatic win(input int len, input logic [255:0] pat, input int next_wl);
      for (int i = 0; i < len; i++) begin
         spike_in = pat[i];
         if (i == len - 1) win_len = 8'(next_wl);
         tick();
      end
      spike_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b1; win_len = 8'd10;
      tick(); tick();
      total_cnt++;
      if ({out_valid, out_count, out_min_isi, out_overrun} !== 18'd0)
         $display("FAIL reset: got v=%0b c=%0d i=%0d o=%0b, want all 0",
                  out_valid, out_count, out_min_isi, out_overrun);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      start(10);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL early_valid: got %0b want 0", out_valid);
            else pass_cnt++;
         end
         tick();
      end
      total_cnt++;
      if ({out_valid, out_count, out_min_isi, out_overrun} !== {1'b1, 8'd0, 8'd255, 1'b0})
         $display("FAIL empty_window: got v=%0b c=%0d i=%0d o=%0b want v=1 c=0 i=255 o=0",
                  out_valid, out_count, out_min_isi, out_overrun);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_pattern();
      logic [255:0] pat = '0;
      pat[2] = 1'b1; pat[7] = 1'b1; pat[12] = 1'b1; pat[17] = 1'b1;
      start(20);
      win(20, pat, 20);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi} !== {1'b1, 8'd4, 8'd5})
         $display("FAIL pattern: got v=%0b c=%0d i=%0d want v=1 c=4 i=5",
                  out_valid, out_count, out_min_isi);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_edges();
      logic [255:0] pat = '0;
      pat[0] = 1'b1; pat[1] = 1'b1; pat[7] = 1'b1;
      start(8);
      win(8, pat, 8);
      total_cnt++;
      if ({out_count, out_min_isi} !== {8'd3, 8'd1})
         $display("FAIL edge_spikes: got c=%0d i=%0d want c=3 i=1", out_count, out_min_isi);
      else pass_cnt++;
      win(8, '0, 8);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi} !== {1'b1, 8'd0, 8'd255})
         $display("FAIL no_carry: got v=%0b c=%0d i=%0d want v=1 c=0 i=255",
                  out_valid, out_count, out_min_isi);
      else pass_cnt++;
      stop();
      // win_len=0 behaves as single-cycle windows
      pat = '0; pat[0] = 1'b1;
      start(0);
      win(1, pat, 0);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi} !== {1'b1, 8'd1, 8'd255})
         $display("FAIL len0_a: got v=%0b c=%0d i=%0d want v=1 c=1 i=255",
                  out_valid, out_count, out_min_isi);
      else pass_cnt++;
      win(1, '0, 0);
      total_cnt++;
      if ({out_valid, out_count} !== {1'b1, 8'd0})
         $display("FAIL len0_b: got v=%0b c=%0d want v=1 c=0", out_valid, out_count);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_overrun();
      logic [255:0] pat;
      out_ready = 1'b0;
      start(10);
      pat = 256'h1;
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_overrun} !== {1'b1, 8'd1, 1'b0})
         $display("FAIL ovr_first: got v=%0b c=%0d o=%0b want v=1 c=1 o=0",
                  out_valid, out_count, out_overrun);
      else pass_cnt++;
      pat = 256'h3;
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count} !== {1'b1, 8'd1})
         $display("FAIL ovr_hold2: got v=%0b c=%0d want v=1 c=1", out_valid, out_count);
      else pass_cnt++;
      pat = 256'h7;
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi, out_overrun} !== {1'b1, 8'd1, 8'd255, 1'b0})
         $display("FAIL ovr_hold3: got v=%0b c=%0d i=%0d o=%0b want v=1 c=1 i=255 o=0",
                  out_valid, out_count, out_min_isi, out_overrun);
      else pass_cnt++;
      out_ready = 1'b1;
      pat = 256'hF;
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_overrun} !== {1'b1, 8'd4, 1'b1})
         $display("FAIL ovr_flag: got v=%0b c=%0d o=%0b want v=1 c=4 o=1",
                  out_valid, out_count, out_overrun);
      else pass_cnt++;
      pat = 256'h1F;
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_overrun} !== {1'b1, 8'd5, 1'b0})
         $display("FAIL ovr_clear: got v=%0b c=%0d o=%0b want v=1 c=5 o=0",
                  out_valid, out_count, out_overrun);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_saturation();
      logic [255:0] pat = '1;
      start(40);
      win(40, pat, 40);
      total_cnt++;
      if ({out_count, out_min_isi} !== {8'd40, 8'd1})
         $display("FAIL sat8: got c=%0d i=%0d want c=40 i=1", out_count, out_min_isi);
      else pass_cnt++;
      total_cnt++;
      if ({o4_valid, o4_count, o4_min_isi} !== {1'b1, 4'd15, 8'd1})
         $display("FAIL sat4: got v=%0b c=%0d i=%0d want v=1 c=15 i=1",
                  o4_valid, o4_count, o4_min_isi);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_abort();
      logic [255:0] pat = '0;
      out_ready = 1'b1;
      start(10);
      for (int i = 0; i < 5; i++) begin
         spike_in = 1'b1;
         tick();
      end
      stop();
      tick(); tick(); tick(); tick(); tick();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL abort_noresult: got v=%0b want 0", out_valid);
      else pass_cnt++;
      pat[3] = 1'b1; pat[6] = 1'b1;
      start(10);
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi} !== {1'b1, 8'd2, 8'd3})
         $display("FAIL abort_next: got v=%0b c=%0d i=%0d want v=1 c=2 i=3",
                  out_valid, out_count, out_min_isi);
      else pass_cnt++;
      // pending result survives a disable while not accepted
      out_ready = 1'b0;
      tick(); tick();
      enable = 1'b0;
      tick(); tick(); tick();
      total_cnt++;
      if ({out_valid, out_count} !== {1'b1, 8'd2})
         $display("FAIL idle_hold: got v=%0b c=%0d want v=1 c=2", out_valid, out_count);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL idle_accept: got v=%0b want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      logic [255:0] pat = 256'h5;
      out_ready = 1'b0;
      start(10);
      win(10, pat, 10);
      win(10, pat, 10);   // dropped, sets sticky overrun
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({out_valid, out_count, out_min_isi, out_overrun} !== 18'd0)
         $display("FAIL async_rst: got v=%0b c=%0d i=%0d o=%0b want all 0",
                  out_valid, out_count, out_min_isi, out_overrun);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1; enable = 1'b0;
      tick();
      pat = 256'h111;
      start(10);
      win(10, pat, 10);
      total_cnt++;
      if ({out_valid, out_count, out_min_isi, out_overrun} !== {1'b1, 8'd3, 8'd4, 1'b0})
         $display("FAIL after_rst: got v=%0b c=%0d i=%0d o=%0b want v=1 c=3 i=4 o=0",
                  out_valid, out_count, out_min_isi, out_overrun);
      else pass_cnt++;
      stop();
   endtask

   task automatic test_back_to_back();
      logic [255:0] pat;
      int len, nxt, dens, ec, ei;
      out_ready = 1'b1;
      len = $urandom_range(1, 30);
      start(len);
      for (int k = 0; k < 12; k++) begin
         nxt  = $urandom_range(1, 30);
         dens = $urandom_range(10, 90);
         pat  = '0;
         for (int i = 0; i < len; i++) pat[i] = ($urandom_range(0, 99) < dens);
         win(len, pat, nxt);
         ec = m_count(pat, len, 255);
         ei = m_isi(pat, len);
         total_cnt++;
         if ({out_valid, out_count, out_min_isi, out_overrun} !== {1'b1, 8'(ec), 8'(ei), 1'b0})
            $display("FAIL rand_win%0d len=%0d: got v=%0b c=%0d i=%0d o=%0b want v=1 c=%0d i=%0d o=0",
                     k, len, out_valid, out_count, out_min_isi, out_overrun, ec, ei);
         else pass_cnt++;
         total_cnt++;
         if (o4_count !== 4'(m_count(pat, len, 15)))
            $display("FAIL rand_cnt4_%0d: got c=%0d want c=%0d", k, o4_count, m_count(pat, len, 15));
         else pass_cnt++;
         len = nxt;
      end
      stop();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_pattern();
      test_edges();
      test_overrun();
      test_saturation();
      test_abort();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
